vec_cache_edge_rd_collector: RTL

- Sits at the east/west/north/south edge of the vector-cache SRAM-group mesh. Terminates the per-channel data-return lanes coming out of the last XY switch.
- Each of CH_N channels has no backpressure from the mesh, so beats are captured into per-channel FIFOs. Only beats whose txnid direction matches DIR_ID are accepted.
- Accepted beats are returned to the requester on a single valid/ready port under round-robin arbitration. Each pop is reported as a per-channel credit so the command issuer can throttle.

---
 rtl/vec_cache_edge_rd_collector.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vec_cache_edge_rd_collector.sv
// vec_cache_edge_rd_collector
// Terminates the per-channel data-return lanes at one edge of the vector-cache
// mesh. Beats whose txnid direction matches DIR_ID are buffered in per-channel
// FIFOs and returned on a single valid/ready port under round-robin arbitration.
// Each pop is reported back to the issuer as a one-cycle per-channel credit.
// Optional build macro: VEC_CACHE_COLLECT_PERF_EN adds saturating perf counters.
module vec_cache_edge_rd_collector #(
    parameter int CH_N    = 8,
    parameter int DATA_W  = 512,
    parameter int TXNID_W = 16,
    parameter int DEPTH   = 4,
    parameter int DIR_ID  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CH_N-1:0]            data_in_vld,
    input  logic [CH_N*DATA_W-1:0]     data_in_pld,
    input  logic [CH_N*TXNID_W-1:0]    data_in_txnid,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [DATA_W-1:0]          out_data,
    output logic [TXNID_W-1:0]         out_txnid,
    output logic [$clog2(CH_N)-1:0]    out_ch,
    output logic [CH_N-1:0]            credit_rtn,
    output logic [CH_N-1:0]            dir_mismatch,
    output logic                       overflow_err
`ifdef VEC_CACHE_COLLECT_PERF_EN
    ,
    output logic [31:0]                perf_beat_cnt,
    output logic [31:0]                perf_drop_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int CH_W  = $clog2(CH_N);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] DIR_BITS = 2'(DIR_ID);

    // Payload storage carries no reset; occupancy/pointers alone decide validity.
    logic [DATA_W-1:0]  mem_data  [CH_N][DEPTH];
    logic [TXNID_W-1:0] mem_txnid [CH_N][DEPTH];

    logic [PTR_W-1:0]   wr_ptr [CH_N];
    logic [PTR_W-1:0]   rd_ptr [CH_N];
    logic [CNT_W-1:0]   count  [CH_N];

    logic [CH_N-1:0]    dir_match;
    logic [CH_N-1:0]    nonempty;
    logic [CH_N-1:0]    full;
    logic [CH_N-1:0]    push_req;
    logic [CH_N-1:0]    push_acc;
    logic [CH_N-1:0]    push_ovf;
    logic [CH_N-1:0]    drop_dir;
    logic [CH_N-1:0]    pop;

    logic [CH_W-1:0]    rr_ptr;
    logic [CH_W-1:0]    arb_ch;
    logic [CH_W-1:0]    win_ch;
    logic [CH_W-1:0]    lock_ch;
    logic               lock_vld;
    logic               handshake;

    // Per-channel status: direction filter, occupancy flags and push decision.
    always_comb begin
        dir_match = '0;
        nonempty  = '0;
        full      = '0;
        for (int i = 0; i < CH_N; i++) begin
            dir_match[i] = (data_in_txnid[i*TXNID_W +: 2] == DIR_BITS);
            nonempty[i]  = (count[i] != '0);
            full[i]      = (count[i] == CNT_W'(DEPTH));
        end
        push_req = data_in_vld & dir_match;
        drop_dir = data_in_vld & ~dir_match;
        // A full FIFO still accepts when its head leaves in the same cycle.
        push_acc = push_req & (~full | pop);
        push_ovf = push_req & full & ~pop;
    end

    // Round-robin search: first non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        int  j;
        logic found;
        found  = 1'b0;
        arb_ch = '0;
        j      = 0;
        for (int k = 0; k < CH_N; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= CH_N) begin
                j = j - CH_N;
            end
            if (!found && nonempty[j]) begin
                found  = 1'b1;
                arb_ch = CH_W'(j);
            end
        end
    end

    // Winner is frozen by the lock while a presented beat waits for out_rdy.
    always_comb begin
        win_ch    = lock_vld ? lock_ch : arb_ch;
        out_vld   = |nonempty;
        handshake = out_vld & out_rdy;
        pop       = handshake ? (CH_N'(1) << win_ch) : '0;
        out_data  = out_vld ? mem_data[win_ch][rd_ptr[win_ch]]  : '0;
        out_txnid = out_vld ? mem_txnid[win_ch][rd_ptr[win_ch]] : '0;
        out_ch    = out_vld ? win_ch : '0;
    end

    // Lock register and round-robin pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld <= 1'b0;
            lock_ch  <= '0;
            rr_ptr   <= '0;
        end else if (handshake) begin
            lock_vld <= 1'b0;
            rr_ptr   <= (win_ch == CH_W'(CH_N - 1)) ? '0 : win_ch + CH_W'(1);
        end else if (out_vld && !lock_vld) begin
            lock_vld <= 1'b1;
            lock_ch  <= arb_ch;
        end
    end

    // FIFO pointers and occupancy counts; reset flushes every buffered beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_N; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CH_N; i++) begin
                if (push_acc[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push_acc[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO payload write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CH_N; i++) begin
            if (push_acc[i]) begin
                mem_data[i][wr_ptr[i]]  <= data_in_pld[i*DATA_W +: DATA_W];
                mem_txnid[i][wr_ptr[i]] <= data_in_txnid[i*TXNID_W +: TXNID_W];
            end
        end
    end

    // Registered event pulses and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_rtn   <= '0;
            dir_mismatch <= '0;
            overflow_err <= 1'b0;
        end else begin
            credit_rtn   <= pop;
            dir_mismatch <= drop_dir;
            overflow_err <= overflow_err | (|push_ovf);
        end
    end

`ifdef VEC_CACHE_COLLECT_PERF_EN
    function automatic logic [31:0] sat_add(input logic [31:0] acc, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_beat_cnt  <= '0;
            perf_drop_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_beat_cnt  <= sat_add(perf_beat_cnt, {31'd0, handshake});
            perf_drop_cnt  <= sat_add(perf_drop_cnt,
                                      32'($countones(drop_dir)) + 32'($countones(push_ovf)));
            perf_stall_cnt <= sat_add(perf_stall_cnt, {31'd0, out_vld & ~out_rdy});
        end
    end
`endif

endmodule
